// File: rtl/ifm_rd_pkg.sv
// Shared constants, tag type and credit-width helper for the ifm SRAM read port.
package ifm_rd_pkg;

  localparam int DW = 8;
  localparam int DN = 8;
  localparam int AW = 14;
  localparam int WW = DW * DN;

  localparam logic [AW-1:0] PAD_ADDR = {AW{1'b1}};

  typedef struct packed {
    logic first;
    logic last;
    logic pad;
  } tag_t;

  // The credit must be able to hold the value FD itself, hence the extra bit.
  function automatic int credit_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/ifm_bank_rd_sync_fifo.sv
// Generic synchronous FIFO with full/empty/count; power-of-two depth, synchronous active-high reset.
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic [W-1:0]               i_wr_data,
  input  logic                       i_rd_en,
  output logic [W-1:0]               o_rd_data,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          w_do_wr;
  logic          w_do_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PW+1)'(DEPTH));
  assign o_count = r_count;
  assign w_do_wr = i_wr_en & ~o_full;
  assign w_do_rd = i_rd_en & ~o_empty;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + PW'(1);
      if (w_do_rd) r_rptr <= r_rptr + PW'(1);
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wptr] <= i_wr_data;
  end

  // Head is masked while empty so stale storage never shows on the output.
  assign o_rd_data = o_empty ? '0 : r_mem[r_rptr];

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst_n) !(i_wr_en && o_full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst_n) !(i_rd_en && o_empty));

endmodule

// File: rtl/ifm_bank_rd.sv
// Credit-flow-controlled ifm SRAM read port: address stream in, tagged data stream out.
// Optional IFM_PAD_EN: all-ones address returns a zero word without touching the SRAM.
module ifm_bank_rd
  import ifm_rd_pkg::*;
#(
  parameter int RL = 1,
  parameter int FD = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] m_addr,
  input  logic          m_addr_first,
  input  logic          m_addr_last,
  input  logic          m_addr_valid,
  output logic          m_addr_ready,
  output logic          sram_cen,
  output logic [AW-1:0] sram_addr,
  input  logic [WW-1:0] sram_rdata,
  output logic [WW-1:0] s_data,
  output logic          s_first,
  output logic          s_last,
  output logic          s_valid,
  input  logic          s_ready
);

  localparam int CW = credit_w(FD);
  localparam int PW = $clog2(FD);
  localparam int EW = WW + 2;

  logic [CW-1:0] r_credit;
  logic          w_accept;
  logic          w_pop;
  logic          w_pad;

  logic          r_cen;
  logic [AW-1:0] r_addr;
  logic          r_iss_vld;
  tag_t          r_iss_tag;

  logic [RL-1:0] r_pipe_vld;
  tag_t          r_pipe_tag [RL];

  tag_t          w_ret_tag;
  logic [WW-1:0] w_ret_word;
  logic          w_fifo_wr;
  logic [EW-1:0] w_fifo_din;
  logic [EW-1:0] w_fifo_dout;
  logic          w_fifo_full;
  logic          w_fifo_empty;
  logic [PW:0]   w_fifo_count;

`ifdef IFM_PAD_EN
  assign w_pad = (m_addr == PAD_ADDR);
`else
  assign w_pad = 1'b0;
`endif

  // Credit counts free return slots: reads in flight plus buffered words never exceed FD.
  assign m_addr_ready = (r_credit != '0) & ~rst_n;
  assign w_accept     = m_addr_valid & m_addr_ready;
  assign w_pop        = s_valid & s_ready;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_credit <= CW'(FD);
    end else begin
      case ({w_accept, w_pop})
        2'b10:   r_credit <= r_credit - CW'(1);
        2'b01:   r_credit <= r_credit + CW'(1);
        default: r_credit <= r_credit;
      endcase
    end
  end

  // Issue stage: a padding slot travels down the pipe but never enables the SRAM.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_cen     <= 1'b0;
      r_addr    <= '0;
      r_iss_vld <= 1'b0;
      r_iss_tag <= '0;
    end else begin
      r_cen     <= w_accept & ~w_pad;
      r_iss_vld <= w_accept;
      if (w_accept) begin
        r_iss_tag <= '{first: m_addr_first, last: m_addr_last, pad: w_pad};
      end
      if (w_accept && !w_pad) begin
        r_addr <= m_addr;
      end
    end
  end

  assign sram_cen  = r_cen;
  assign sram_addr = r_addr;

  // Tag pipeline: the last stage lines up with sram_rdata for the same read.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_pipe_vld <= '0;
      for (int i = 0; i < RL; i++) begin
        r_pipe_tag[i] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= r_iss_vld;
      r_pipe_tag[0] <= r_iss_tag;
      for (int i = 1; i < RL; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1];
        r_pipe_tag[i] <= r_pipe_tag[i-1];
      end
    end
  end

  assign w_ret_tag  = r_pipe_tag[RL-1];
  assign w_fifo_wr  = r_pipe_vld[RL-1];
  assign w_ret_word = w_ret_tag.pad ? '0 : sram_rdata;
  assign w_fifo_din = {w_ret_word, w_ret_tag.first, w_ret_tag.last};

  sync_fifo #(
    .W     (EW),
    .DEPTH (FD)
  ) u_ret_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_fifo_wr),
    .i_wr_data (w_fifo_din),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_dout),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign s_valid                   = ~w_fifo_empty;
  assign {s_data, s_first, s_last} = w_fifo_dout;

  a_credit_max:   assert property (@(posedge clk) disable iff (rst_n) r_credit <= CW'(FD));
  a_credit_space: assert property (@(posedge clk) disable iff (rst_n)
                                   (32'(r_credit) + 32'(w_fifo_count)) <= FD);
  a_no_wr_full:   assert property (@(posedge clk) disable iff (rst_n) !(w_fifo_wr && w_fifo_full));

endmodule

// File: tb/tb_ifm_bank_rd.sv
// Bench for ifm_bank_rd: in-order latency/ready model checked every cycle plus directed tests.
`timescale 1ns/1ps
module tb_ifm_bank_rd;
  import ifm_rd_pkg::*;

  localparam int RL = 1;
  localparam int FD = 4;
`ifdef IFM_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] m_addr;
  logic          m_addr_first, m_addr_last, m_addr_valid, m_addr_ready;
  logic          sram_cen;
  logic [AW-1:0] sram_addr;
  logic [WW-1:0] sram_rdata;
  logic [WW-1:0] s_data;
  logic          s_first, s_last, s_valid, s_ready;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ifm_bank_rd #(.RL(RL), .FD(FD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .m_addr       (m_addr),
    .m_addr_first (m_addr_first),
    .m_addr_last  (m_addr_last),
    .m_addr_valid (m_addr_valid),
    .m_addr_ready (m_addr_ready),
    .sram_cen     (sram_cen),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .s_data       (s_data),
    .s_first      (s_first),
    .s_last       (s_last),
    .s_valid      (s_valid),
    .s_ready      (s_ready)
  );

  function automatic logic [WW-1:0] pattern(input logic [AW-1:0] a);
    logic [15:0] w;
    w = 16'(a);
    return {w + 16'h1111, w ^ 16'hA5A5, ~w, w};
  endfunction

  function automatic logic [WW-1:0] exp_word(input logic [AW-1:0] a);
    if (PAD_EN && a == {AW{1'b1}}) return '0;
    return pattern(a);
  endfunction

  // SRAM: read data appears RL cycles after sram_cen; junk otherwise.
  logic [WW-1:0] sram_q [RL];
  always @(posedge clk) begin
    sram_q[0] <= sram_cen ? pattern(sram_addr) : {$urandom(), $urandom()};
    for (int i = 1; i < RL; i++) sram_q[i] <= sram_q[i-1];
  end
  assign sram_rdata = sram_q[RL-1];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  // Model: every accepted address owes one word, due RL+2 cycles after the accept, in order.
  typedef struct {
    logic [WW-1:0] data;
    logic          first;
    logic          last;
    int            due;
  } exp_t;

  exp_t          exp_q[$];
  int            occ = 0;
  logic          prev_acc = 1'b0;
  logic          prev_pad = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  int            acc_cyc[$];
  logic [WW-1:0] pop_data[$];
  logic          pop_first[$];
  logic          pop_last[$];
  int            pop_cyc[$];
  int            cen_cnt = 0;

  always @(negedge clk) begin
    logic exp_valid;
    exp_t e;
    if (rst_n) begin
      check("ready_in_reset", m_addr_ready, 0);
      exp_q.delete();
      occ      = 0;
      prev_acc = 1'b0;
    end else begin
      check("m_addr_ready", m_addr_ready, occ < FD);
      exp_valid = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
      check("s_valid", s_valid, exp_valid);
      if (exp_valid && s_valid) begin
        e = exp_q[0];
        check("s_data", s_data, e.data);
        check("s_first", s_first, e.first);
        check("s_last", s_last, e.last);
      end
      check("sram_cen", sram_cen, prev_acc && !prev_pad);
      if (prev_acc && !prev_pad) check("sram_addr", sram_addr, prev_addr);
      if (sram_cen) cen_cnt++;
      if (s_valid && s_ready) begin
        pop_data.push_back(s_data);
        pop_first.push_back(s_first);
        pop_last.push_back(s_last);
        pop_cyc.push_back(cyc);
      end
      if (exp_valid && s_ready) begin
        void'(exp_q.pop_front());
        occ--;
      end
      prev_acc  = m_addr_valid && m_addr_ready;
      prev_pad  = PAD_EN && (m_addr == {AW{1'b1}});
      prev_addr = m_addr;
      if (prev_acc) begin
        e.data  = exp_word(m_addr);
        e.first = m_addr_first;
        e.last  = m_addr_last;
        e.due   = cyc + RL + 2;
        exp_q.push_back(e);
        occ++;
        acc_cyc.push_back(cyc);
      end
    end
  end

  int stalls = 0;

  task automatic send(input logic [AW-1:0] a, input logic f, input logic l);
    int g;
    m_addr = a;
    m_addr_first = f;
    m_addr_last = l;
    m_addr_valid = 1'b1;
    g = 0;
    @(negedge clk);
    if (!m_addr_ready) stalls++;
    while (!m_addr_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!m_addr_ready) timeout("send");
    @(posedge clk);
    #1;
    m_addr_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target, input string name);
    int g;
    g = 0;
    while (pop_data.size() < target && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (pop_data.size() < target) timeout(name);
  endtask

  task automatic wait_idle(input string name);
    int g;
    g = 0;
    while (occ != 0 && g < 500) begin
      @(negedge clk);
      g++;
    end
    if (occ != 0) timeout(name);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_p, base_a, base_c, k, g;
    rst_n = 1'b1;
    m_addr = '0;
    m_addr_first = 1'b0;
    m_addr_last = 1'b0;
    m_addr_valid = 1'b0;
    s_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sram_cen", sram_cen, 0);
    check("rst_sram_addr", sram_addr, 0);
    check("rst_s_valid", s_valid, 0);
    check("rst_s_data", s_data, 0);
    check("rst_s_first", s_first, 0);
    check("rst_s_last", s_last, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;

    // Single burst 0x10..0x12
    s_ready = 1'b1;
    base_p = pop_data.size();
    base_a = acc_cyc.size();
    send(14'h010, 1'b1, 1'b0);
    send(14'h011, 1'b0, 1'b0);
    send(14'h012, 1'b0, 1'b1);
    wait_pops(base_p + 3, "burst_pops");
    check("burst_w0", pop_data[base_p], 64'h1121_A5B5_FFEF_0010);
    check("burst_w2", pop_data[base_p+2], 64'h1123_A5B7_FFED_0012);
    check("burst_first0", pop_first[base_p], 1);
    check("burst_first1", pop_first[base_p+1], 0);
    check("burst_last0", pop_last[base_p], 0);
    check("burst_last2", pop_last[base_p+2], 1);
    check("burst_latency", 64'(pop_cyc[base_p] - acc_cyc[base_a]), 3);
    wait_idle("burst_idle");

    // Streaming 64 addresses at full rate
    stalls = 0;
    base_p = pop_data.size();
    for (int i = 0; i < 64; i++) send(AW'(14'h100 + i), i == 0, i == 63);
    wait_pops(base_p + 64, "stream_pops");
    check("stream_stalls", stalls, 0);
    check("stream_span", 64'(pop_cyc[base_p+63] - pop_cyc[base_p]), 63);
    wait_idle("stream_idle");

    // Backpressure: 20 cycles of s_ready=0 with valid held high
    s_ready = 1'b0;
    base_p = pop_data.size();
    k = 0;
    m_addr_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      m_addr = AW'(14'h200 + k);
      m_addr_first = (k == 0);
      m_addr_last = 1'b0;
      @(negedge clk);
      if (m_addr_ready) k++;
      @(posedge clk);
      #1;
    end
    m_addr_valid = 1'b0;
    check("bp_accepts", k, FD);
    @(negedge clk);
    check("bp_ready_low", m_addr_ready, 0);
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    wait_pops(base_p + FD, "bp_pops");
    repeat (10) @(negedge clk);
    check("bp_pop_count", pop_data.size() - base_p, FD);
    check("bp_w0", pop_data[base_p], 64'h1311_A7A5_FDFF_0200);
    wait_idle("bp_idle");

    // Random valid/ready over 10k transfers
    base_p = pop_data.size();
    base_a = acc_cyc.size();
    g = 0;
    while (acc_cyc.size() - base_a < 10000 && g < 60000) begin
      m_addr = AW'($urandom());
      m_addr_first = 1'($urandom_range(0, 1));
      m_addr_last = 1'($urandom_range(0, 1));
      m_addr_valid = ($urandom_range(0, 9) < 7);
      s_ready = ($urandom_range(0, 9) < 6);
      @(posedge clk);
      #1;
      g++;
    end
    if (acc_cyc.size() - base_a < 10000) timeout("rand_accepts");
    m_addr_valid = 1'b0;
    s_ready = 1'b1;
    wait_idle("rand_idle");
    check("rand_pop_count", pop_data.size() - base_p, acc_cyc.size() - base_a);

    // Reset with 2 words buffered and 2 reads in flight
    s_ready = 1'b0;
    send(14'h300, 1'b1, 1'b0);
    send(14'h301, 1'b0, 1'b0);
    send(14'h302, 1'b0, 1'b0);
    send(14'h303, 1'b0, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_s_valid", s_valid, 0);
    check("mrst_ready", m_addr_ready, 1);
    @(posedge clk);
    #1;
    s_ready = 1'b1;
    base_p = pop_data.size();
    repeat (6) @(negedge clk);
    check("mrst_no_stale", pop_data.size() - base_p, 0);
    @(posedge clk);
    #1;
    send(14'h040, 1'b1, 1'b0);
    send(14'h041, 1'b0, 1'b0);
    send(14'h042, 1'b0, 1'b1);
    wait_pops(base_p + 3, "mrst_pops");
    check("mrst_w0", pop_data[base_p], 64'h1151_A5E5_FFBF_0040);
    check("mrst_first0", pop_first[base_p], 1);
    check("mrst_last2", pop_last[base_p+2], 1);
    wait_idle("mrst_idle");

    // All-ones address burst
    base_p = pop_data.size();
    base_c = cen_cnt;
    send(14'h3FFF, 1'b1, 1'b0);
    send(14'h0005, 1'b0, 1'b0);
    send(14'h3FFF, 1'b0, 1'b1);
    wait_pops(base_p + 3, "pad_pops");
    wait_idle("pad_idle");
`ifdef IFM_PAD_EN
    check("pad_cen_pulses", cen_cnt - base_c, 1);
    check("pad_w0", pop_data[base_p], 64'h0);
    check("pad_w2", pop_data[base_p+2], 64'h0);
`else
    check("pad_cen_pulses", cen_cnt - base_c, 3);
    check("pad_w0", pop_data[base_p], 64'h5110_9A5A_C000_3FFF);
    check("pad_w2", pop_data[base_p+2], 64'h5110_9A5A_C000_3FFF);
`endif
    check("pad_w1", pop_data[base_p+1], 64'h1116_A5A0_FFFA_0005);
    check("pad_first0", pop_first[base_p], 1);
    check("pad_last2", pop_last[base_p+2], 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
